// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, RV32 funct3 size codes,
// bus widths and the misalignment rule.
package load_store_unit_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned FUNCT_W = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } lsu_state_e;

  typedef enum logic [FUNCT_W-1:0] {
    MF_B  = 3'b000,
    MF_H  = 3'b001,
    MF_W  = 3'b010,
    MF_BU = 3'b100,
    MF_HU = 3'b101
  } mem_funct_e;

  // Word needs addr[1:0]==0, half needs addr[0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [FUNCT_W-1:0] funct,
                                         input logic [1:0]         addr_lo);
    case (funct)
      MF_W:        return addr_lo != 2'b00;
      MF_H, MF_HU: return addr_lo[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   funct_i    - RV32 funct3 size/sign code
//   addr_lo_i  - byte offset within the word
//   rdata_i    - raw read word from the bus
//   wdata_i    - store source (rs2)
//   load_o     - selected lane, sign/zero extended
//   strobe_o   - byte enables for the store
//   wdata_o    - store data replicated across lanes
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [DATA_W-1:0]  rdata_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  load_o,
  output logic [STRB_W-1:0]  strobe_o,
  output logic [DATA_W-1:0]  wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Load extraction and extension.
  always_comb begin
    load_o = rdata_i;
    case (funct_i)
      MF_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      MF_BU:   load_o = {24'h000000, byte_sel};
      MF_H:    load_o = {{16{half_sel[15]}}, half_sel};
      MF_HU:   load_o = {16'h0000, half_sel};
      default: load_o = rdata_i;
    endcase
  end

  // Store strobes and lane replication.
  always_comb begin
    strobe_o = 4'b1111;
    wdata_o  = wdata_i;
    case (funct_i)
      MF_B, MF_BU: begin
        strobe_o = STRB_W'(4'b0001) << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      MF_H, MF_HU: begin
        strobe_o = STRB_W'(4'b0011) << {addr_lo_i[1], 1'b0};
        wdata_o  = {2{wdata_i[15:0]}};
      end
      default: begin
        strobe_o = 4'b1111;
        wdata_o  = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-side bus master driven by the control unit's MEM state.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   load_data/store_data           - one-cycle start pulses (store wins)
//   addr, store_din, mem_funct     - access description, sampled on the pulse
//   data_valid, misaligned, bus_err- completion pulse and its status flags
//   load_dout                      - aligned load result, held until next load
//   busy                           - transaction in progress
//   dr_*                           - read request / response channels
//   dw_*                           - write request / response channels
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_data,
  input  logic                  store_data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_din,
  input  logic [2:0]            mem_funct,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] load_dout,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic                  busy,
  output logic                  dr_addr_valid,
  input  logic                  dr_addr_ready,
  output logic [ADDR_WIDTH-1:0] dr_addr,
  input  logic                  dr_data_valid,
  output logic                  dr_data_ready,
  input  logic [DATA_WIDTH-1:0] dr_data,
  input  logic                  dr_err,
  output logic                  dw_valid,
  input  logic                  dw_ready,
  output logic [ADDR_WIDTH-1:0] dw_addr,
  output logic [DATA_WIDTH-1:0] dw_data,
  output logic [STRB_WIDTH-1:0] dw_strobe,
  input  logic                  dw_resp_valid,
  output logic                  dw_resp_ready,
  input  logic                  dw_err
);

  lsu_state_e state_q, state_d;

  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [FUNCT_W-1:0]    funct_q, funct_d;
  logic                  mis_q, mis_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0] load_dout_q, load_dout_d;

  logic data_valid_q, misaligned_q, bus_err_q, busy_q;
  logic dr_addr_valid_q, dr_data_ready_q, dw_valid_q, dw_resp_ready_q;

  logic                  start;
  logic                  start_mis;
  logic [FUNCT_W-1:0]    al_funct;
  logic [1:0]            al_addr_lo;
  logic [DATA_WIDTH-1:0] al_load, al_wdata;
  logic [STRB_WIDTH-1:0] al_strobe;

  assign start     = load_data | store_data;
  assign start_mis = is_misaligned(mem_funct, addr[1:0]);

  // In IDLE the aligner sees the live pulse inputs (store lanes are latched
  // on the pulse); afterwards it sees the captured access for load extraction.
  assign al_funct   = (state_q == ST_IDLE) ? mem_funct : funct_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct_i   (al_funct),
    .addr_lo_i (al_addr_lo),
    .rdata_i   (dr_data),
    .wdata_i   (store_din),
    .load_o    (al_load),
    .strobe_o  (al_strobe),
    .wdata_o   (al_wdata)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    funct_d     = funct_q;
    mis_d       = mis_q;
    err_d       = err_q;
    req_addr_d  = req_addr_q;
    wdata_d     = wdata_q;
    strobe_d    = strobe_q;
    load_dout_d = load_dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_lo_d  = addr[1:0];
          funct_d    = mem_funct;
          mis_d      = start_mis;
          err_d      = 1'b0;
          req_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
          if (store_data) begin
            wdata_d  = al_wdata;
            strobe_d = al_strobe;
            state_d  = start_mis ? ST_DONE : ST_WR_REQ;
          end else begin
            if (start_mis) load_dout_d = '0;
            state_d = start_mis ? ST_DONE : ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ:  if (dr_addr_ready) state_d = ST_RD_RESP;
      ST_RD_RESP: begin
        if (dr_data_valid) begin
          load_dout_d = al_load;
          err_d       = dr_err;
          state_d     = ST_DONE;
        end
      end
      ST_WR_REQ:  if (dw_ready) state_d = ST_WR_RESP;
      ST_WR_RESP: begin
        if (dw_resp_valid) begin
          err_d   = dw_err;
          state_d = ST_DONE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, captured fields and registered outputs (decoded from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_lo_q       <= '0;
      funct_q         <= '0;
      mis_q           <= 1'b0;
      err_q           <= 1'b0;
      req_addr_q      <= '0;
      wdata_q         <= '0;
      strobe_q        <= '0;
      load_dout_q     <= '0;
      data_valid_q    <= 1'b0;
      misaligned_q    <= 1'b0;
      bus_err_q       <= 1'b0;
      busy_q          <= 1'b0;
      dr_addr_valid_q <= 1'b0;
      dr_data_ready_q <= 1'b0;
      dw_valid_q      <= 1'b0;
      dw_resp_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_lo_q       <= addr_lo_d;
      funct_q         <= funct_d;
      mis_q           <= mis_d;
      err_q           <= err_d;
      req_addr_q      <= req_addr_d;
      wdata_q         <= wdata_d;
      strobe_q        <= strobe_d;
      load_dout_q     <= load_dout_d;
      data_valid_q    <= (state_d == ST_DONE);
      misaligned_q    <= (state_d == ST_DONE) && mis_d;
      bus_err_q       <= (state_d == ST_DONE) && err_d;
      busy_q          <= (state_d != ST_IDLE);
      dr_addr_valid_q <= (state_d == ST_RD_REQ);
      dr_data_ready_q <= (state_d == ST_RD_RESP);
      dw_valid_q      <= (state_d == ST_WR_REQ);
      dw_resp_ready_q <= (state_d == ST_WR_RESP);
    end
  end

  assign data_valid    = data_valid_q;
  assign misaligned    = misaligned_q;
  assign bus_err       = bus_err_q;
  assign busy          = busy_q;
  assign load_dout     = load_dout_q;
  assign dr_addr_valid = dr_addr_valid_q;
  assign dr_addr       = req_addr_q;
  assign dr_data_ready = dr_data_ready_q;
  assign dw_valid      = dw_valid_q;
  assign dw_addr       = req_addr_q;
  assign dw_data       = wdata_q;
  assign dw_strobe     = strobe_q;
  assign dw_resp_ready = dw_resp_ready_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-side memory interface between the control unit's MEM state and the data bus.
- Accepts one-cycle load_data/store_data pulses with the ALU-computed address and rs2 value.
- Runs one bus transaction with valid/ready handshakes, aligns and sign-extends load data, and returns a one-cycle data_valid pulse that ends the control unit's MEM state.
- load_dout feeds the register-file write mux (RD_DIN_SEL_MEM path).

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, bus data width; only 32 is supported
- STRB_WIDTH, 4, byte strobes (DATA_WIDTH/8)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- load_data  in  1  one-cycle pulse: start load
- store_data  in  1  one-cycle pulse: start store
- addr  in  ADDR_WIDTH  byte address (ALU result), sampled on pulse
- store_din  in  DATA_WIDTH  rs2 value, sampled on pulse
- mem_funct  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; sampled on pulse
- data_valid  out  1  one-cycle completion pulse
- load_dout  out  DATA_WIDTH  aligned/extended load result; held until next load completes
- misaligned  out  1  pulses with data_valid when the access was misaligned
- bus_err  out  1  pulses with data_valid when the response error bit was set
- busy  out  1  high from pulse+1 until data_valid cycle inclusive
- dr_addr_valid / dr_addr_ready  out/in  1  read request handshake
- dr_addr  out  ADDR_WIDTH  word-aligned read address
- dr_data_valid / dr_data_ready  in/out  1  read response handshake
- dr_data  in  DATA_WIDTH  read data
- dr_err  in  1  read response error
- dw_valid / dw_ready  out/in  1  write request handshake
- dw_addr  out  ADDR_WIDTH  word-aligned write address
- dw_data  out  DATA_WIDTH  lane-replicated write data
- dw_strobe  out  STRB_WIDTH  byte enables
- dw_resp_valid / dw_resp_ready  in/out  1  write response handshake
- dw_err  in  1  write response error

Behaviour:
- Reset, asynchronous: all outputs 0, load_dout=0, FSM returns to IDLE immediately. Any in-flight transaction is abandoned with no data_valid.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE.
- IDLE:
  - store_data → WR_REQ.
  - load_data → RD_REQ.
  - Both high together → store wins; load ignored.
  - Misaligned access → DONE directly with no bus activity: W with addr[1:0]≠0, or H/HU with addr[0]≠0.
  - addr, store_din and mem_funct are registered on the pulse.
- Pulses arriving while busy are ignored.
- RD_REQ: dr_addr_valid=1, dr_addr={addr[31:2],2'b00}. Valid and address are held stable until dr_addr_ready; on handshake → RD_RESP.
- RD_RESP: dr_data_ready=1. On dr_data_valid, capture the extracted value into load_dout and capture dr_err, then → DONE.
- Load extraction:
  - Byte lane = addr[1:0]*8; half lane = addr[1]*16.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- WR_REQ: dw_valid=1 and held stable until dw_ready, then → WR_RESP.
  - Strobes: B gives 4'b0001<<addr[1:0]; H gives 4'b0011<<{addr[1],1'b0}; W gives 4'b1111.
  - Data: byte replicated ×4, half ×2, word as-is.
- WR_RESP: dw_resp_ready=1. On dw_resp_valid, capture dw_err, then → DONE.
- DONE: data_valid=1 for exactly one cycle, with misaligned/bus_err as captured, then → IDLE.
- Misaligned load: load_dout=0.
- Latency:
  - Pulse at T → request valid at T+1.
  - Response handshake at R → data_valid at R+1.
  - Minimum load or store completes in 4 cycles with zero-wait bus.
- load_dout is stable in the data_valid cycle and until the next load's DONE. Stores never change it.
- Request and response handshakes never complete in the same cycle; the response is accepted only in the *_RESP state.

Decomposition:
- Shared header additions:
  - LSU state encodings and STATE width.
  - MEM_FUNCT codes (B/H/W/BU/HU) and width.
  - Strobe width.
- One sub-module: lsu_align, combinational. It does load extraction/extension plus store strobe/replication, and is reusable by tests.

Test Plan:
- LW addr 0x100, bus returns 0xDEADBEEF, zero-wait → dr_addr 0x100, load_dout 0xDEADBEEF, data_valid 4 cycles after pulse, errors 0.
- LB addr 0x103, dr_data 0x80112233 → load_dout 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x00008011.
- SB addr 0x201, store_din 0x000000A5 → dw_addr 0x200, dw_strobe 4'b0010, dw_data 0xA5A5A5A5; SH addr 0x202 → strobe 4'b1100.
- LW addr 0x102 → no dr_addr_valid, data_valid+misaligned 2 cycles after pulse, load_dout 0.
- dr_addr_ready held low 5 cycles, then dr_err=1 on response → dr_addr stable throughout, data_valid with bus_err=1.
- rst asserted during RD_RESP → outputs 0 same cycle, no data_valid. A following SW at 0x0 with data 0x12345678 completes normally.
